// File: rtl/divider_32b.sv
// Multi-cycle restoring shift-subtract divider: one trial subtraction per clock, WIDTH iterations.
// Optional signed operation is enabled by defining DIVIDER_SIGNED_EN (adds the is_signed port).
module divider_32b #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIVIDER_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] wq_q, wq_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sgn_a, sgn_b;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] rem_n, wq_n;

`ifdef DIVIDER_SIGNED_EN
  always_comb begin
    sgn_a = is_signed & dividend[WIDTH-1];
    sgn_b = is_signed & divisor[WIDTH-1];
    mag_a = sgn_a ? -dividend : dividend;
    mag_b = sgn_b ? -divisor  : divisor;
  end
`else
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    mag_a = dividend;
    mag_b = divisor;
  end
`endif

  // The shifted partial remainder is kept at WIDTH+1 bits so divisors with the
  // MSB set never lose the bit shifted out of rem.
  always_comb begin
    rem_sh = {rem_q, wq_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvsr_q};
    if (!trial[WIDTH]) begin
      rem_n = trial[WIDTH-1:0];
      wq_n  = {wq_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = rem_sh[WIDTH-1:0];
      wq_n  = {wq_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvsr_d      = dvsr_q;
    rem_d       = rem_q;
    wq_d        = wq_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      RUN: begin
        rem_d = rem_n;
        wq_d  = wq_n;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          quotient_d  = neg_quo_q ? -wq_n  : wq_n;
          remainder_d = neg_rem_q ? -rem_n : rem_n;
          dbz_d       = 1'b0;
        end
      end
      default: begin
        if (start) begin
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d   = RUN;
            dvsr_d    = mag_b;
            wq_d      = mag_a;
            rem_d     = '0;
            cnt_d     = CW'(WIDTH);
            neg_quo_d = sgn_a ^ sgn_b;
            neg_rem_d = sgn_a;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvsr_q      <= '0;
      rem_q       <= '0;
      wq_q        <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvsr_q      <= dvsr_d;
      rem_q       <= rem_d;
      wq_q        <= wq_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_32b.sv
// Directed self-checking bench for divider_32b; signed vectors run when DIVIDER_SIGNED_EN is defined.
module tb_divider_32b;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
`ifdef DIVIDER_SIGNED_EN
  logic        is_signed = 1'b0;
`endif
  int errors = 0;
  int checks = 0;

  divider_32b #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
`ifdef DIVIDER_SIGNED_EN
    .is_signed(is_signed),
`endif
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Drive a request at a falling edge; the next rising edge is the accepting edge E0.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
  endtask

  // Sample at each falling edge until done; cyc=k means done appeared after edge E(k-1).
  task automatic wait_done(input int pulse_at, output int cyc, output int bcnt, output int overlap);
    cyc = 0; bcnt = 0; overlap = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = (cyc == pulse_at);
      if (cyc == pulse_at) begin dividend = 32'd1; divisor = 32'd1; end
      if (busy) bcnt++;
      if (busy && done) overlap++;
      if (done) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b q=%h r=%h dbz=%b, expected all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int cyc, bcnt, ov;
    launch(32'd100, 32'd7);
    wait_done(0, cyc, bcnt, ov);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL 100/7 latency: got %0d edges, expected 32", cyc-1); end
    checks++; if (bcnt !== 32) begin errors++; $display("FAIL 100/7 busy: got %0d cycles, expected 32", bcnt); end
    checks++; if (ov !== 0) begin errors++; $display("FAIL 100/7 overlap: busy&done seen %0d times, expected 0", ov); end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {32'd14, 32'd2, 1'b0}) begin
      errors++; $display("FAIL 100/7 result: got q=%0d r=%0d dbz=%b, expected q=14 r=2 dbz=0", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done width: done=%b one cycle later, expected 0", done); end
  endtask

  task automatic test_extremes;
    int cyc, bcnt, ov;
    logic [31:0] a [3] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF};
    logic [31:0] b [3] = '{32'd1, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] eq [3] = '{32'hFFFFFFFF, 32'd0, 32'd1};
    logic [31:0] er [3] = '{32'd0, 32'd5, 32'd1};
    for (int i = 0; i < 3; i++) begin
      launch(a[i], b[i]);
      wait_done(0, cyc, bcnt, ov);
      checks++;
      if (cyc !== 33 || quotient !== eq[i] || remainder !== er[i]) begin
        errors++;
        $display("FAIL extreme %h/%h: got q=%h r=%h edges=%0d, expected q=%h r=%h edges=32",
                 a[i], b[i], quotient, remainder, cyc-1, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_by_zero;
    int cyc, bcnt, ov;
    launch(32'd5, 32'd0);
    wait_done(0, cyc, bcnt, ov);
    checks++; if (cyc !== 1 || bcnt !== 0) begin errors++; $display("FAIL dbz timing: got edges=%0d busy=%0d, expected edges=0 busy=0", cyc-1, bcnt); end
    checks++;
    if ({quotient, remainder, div_by_zero} !== {32'hFFFFFFFF, 32'd5, 1'b1}) begin
      errors++; $display("FAIL dbz result: got q=%h r=%h dbz=%b, expected q=ffffffff r=5 dbz=1", quotient, remainder, div_by_zero);
    end
    repeat (2) @(negedge clk);
    checks++; if (div_by_zero !== 1'b1 || quotient !== 32'hFFFFFFFF) begin errors++; $display("FAIL dbz hold: got q=%h dbz=%b in idle, expected q=ffffffff dbz=1", quotient, div_by_zero); end
    launch(32'd9, 32'd3);
    wait_done(0, cyc, bcnt, ov);
    checks++;
    if ({quotient, remainder, div_by_zero} !== {32'd3, 32'd0, 1'b0} || cyc !== 33) begin
      errors++; $display("FAIL 9/3 after dbz: got q=%0d r=%0d dbz=%b edges=%0d, expected q=3 r=0 dbz=0 edges=32", quotient, remainder, div_by_zero, cyc-1);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bcnt, ov;
    launch(32'd1000, 32'd10);
    wait_done(10, cyc, bcnt, ov);
    checks++;
    if ({quotient, remainder} !== {32'd100, 32'd0} || cyc !== 33) begin
      errors++; $display("FAIL 1000/10 with ignored start: got q=%0d r=%0d edges=%0d, expected q=100 r=0 edges=32", quotient, remainder, cyc-1);
    end
    dividend = 32'd77; divisor = 32'd7; start = 1'b1;
    wait_done(0, cyc, bcnt, ov);
    checks++;
    if ({quotient, remainder} !== {32'd11, 32'd0} || cyc !== 33 || bcnt !== 32 || ov !== 0) begin
      errors++; $display("FAIL back-to-back 77/7: got q=%0d r=%0d edges=%0d busy=%0d ov=%0d, expected q=11 r=0 edges=32 busy=32 ov=0",
                         quotient, remainder, cyc-1, bcnt, ov);
    end
  endtask

  task automatic test_abort;
    int cyc, bcnt, ov;
    int early_done = 0;
    launch(32'd1000, 32'd10);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) early_done++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 67'd0 || early_done !== 0) begin
      errors++; $display("FAIL abort: got busy=%b done=%b q=%h r=%h dbz=%b early_done=%0d, expected all 0",
                         busy, done, quotient, remainder, div_by_zero, early_done);
    end
    rst = 1'b0; dividend = 32'd200; divisor = 32'd3; start = 1'b1;
    wait_done(0, cyc, bcnt, ov);
    checks++;
    if ({quotient, remainder} !== {32'd66, 32'd2} || cyc !== 33) begin
      errors++; $display("FAIL start after abort 200/3: got q=%0d r=%0d edges=%0d, expected q=66 r=2 edges=32", quotient, remainder, cyc-1);
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 32'd5; divisor = 32'd0;
    @(negedge clk);
    checks++;
    if ({done, div_by_zero, quotient} !== 34'd0) begin
      errors++; $display("FAIL rst priority: got done=%b dbz=%b q=%h, expected 0 0 0", done, div_by_zero, quotient);
    end
    rst = 1'b0; start = 1'b0;
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed;
    int cyc, bcnt, ov;
    logic        s  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] a  [4] = '{32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFF9, 32'h80000000};
    logic [31:0] b  [4] = '{32'd2, 32'hFFFFFFFF, 32'd2, 32'd0};
    logic [31:0] eq [4] = '{32'hFFFFFFFD, 32'h80000000, 32'h7FFFFFFC, 32'hFFFFFFFF};
    logic [31:0] er [4] = '{32'hFFFFFFFF, 32'd0, 32'd1, 32'h80000000};
    int          el [4] = '{33, 33, 33, 1};
    for (int i = 0; i < 4; i++) begin
      is_signed = s[i];
      launch(a[i], b[i]);
      wait_done(0, cyc, bcnt, ov);
      checks++;
      if (quotient !== eq[i] || remainder !== er[i] || cyc !== el[i]) begin
        errors++; $display("FAIL signed=%b %h/%h: got q=%h r=%h edges=%0d, expected q=%h r=%h edges=%0d",
                           s[i], a[i], b[i], quotient, remainder, cyc-1, eq[i], er[i], el[i]-1);
      end
    end
    is_signed = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_extremes;
    test_div_by_zero;
    test_back_to_back;
    test_abort;
`ifdef DIVIDER_SIGNED_EN
    test_signed;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
